// File: rtl/picorv32_console_bridge_pkg.sv
// ----------------------------------------------------------------------------
// picorv32_console_pkg
// Shared definitions for the picorv32 console bridge.
//   - console_state_t   : console access FSM states (IDLE, ACK)
//   - STATUS_FULL_BIT   : status register bit reporting "TX FIFO full"
//   - STATUS_EMPTY_BIT  : status register bit reporting "TX FIFO empty"
//   - STATUS_OFFSET     : byte offset of the status register from the TX register
//   - status_word()     : packs the status register read value
//   - xorshift32_step() : one step of the xorshift32 stall generator
// ----------------------------------------------------------------------------
package picorv32_console_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } console_state_t;

    localparam int          STATUS_FULL_BIT  = 31;
    localparam int          STATUS_EMPTY_BIT = 30;
    localparam logic [31:0] STATUS_OFFSET    = 32'd4;

    // Status layout: {full, empty, 22'b0, count[7:0]}.
    function automatic logic [31:0] status_word(input logic       full,
                                                input logic       empty,
                                                input logic [7:0] count_lo);
        logic [31:0] word;
        word                   = 32'd0;
        word[STATUS_FULL_BIT]  = full;
        word[STATUS_EMPTY_BIT] = empty;
        word[7:0]              = count_lo;
        return word;
    endfunction

    // Classic Marsaglia xorshift32 (13, 17, 5). Never reaches zero from a
    // nonzero seed, so bit 0 keeps toggling pseudo-randomly.
    function automatic logic [31:0] xorshift32_step(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

endpackage

// File: rtl/picorv32_console_bridge_if.sv
// ----------------------------------------------------------------------------
// picorv32_console_bridge_if
// picorv32 native memory bus bundle, used both on the CPU side and on the RAM
// side of the bridge.
//   valid  : request
//   instr  : instruction fetch flag
//   addr   : byte address
//   wdata  : write data
//   wstrb  : byte strobes, 0 = read
//   ready  : access complete
//   rdata  : read data, valid while ready == 1
// Modports:
//   master : issues requests (CPU, or the bridge towards RAM)
//   slave  : answers requests (the bridge towards the CPU, or RAM)
// ----------------------------------------------------------------------------
interface picorv32_console_bridge_if;

    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;

    modport master (
        output valid,
        output instr,
        output addr,
        output wdata,
        output wstrb,
        input  ready,
        input  rdata
    );

    modport slave (
        input  valid,
        input  instr,
        input  addr,
        input  wdata,
        input  wstrb,
        output ready,
        output rdata
    );

endinterface

// File: rtl/picorv32_console_bridge_fifo.sv
// ----------------------------------------------------------------------------
// console_fifo
// Synchronous FIFO holding console TX bytes.
// Parameters:
//   WIDTH : entry width in bits
//   DEPTH : number of entries, power of two, 2..256
// Ports:
//   clk, reset : clock, asynchronous active-high reset (pointers/count only)
//   push, din  : write an entry (ignored while full)
//   full       : DEPTH entries held
//   pop, dout  : remove the head entry (ignored while empty); dout = head
//   empty      : no entries held
//   count      : occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module console_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int            AW         = $clog2(DEPTH);
    localparam int            CW         = AW + 1;
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers are exactly AW bits wide, so wrapping modulo DEPTH is free.
    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = storage[rd_ptr];

    // Data storage carries no reset: stale entries are unreachable once the
    // pointers are cleared.
    always_ff @(posedge clk) begin
        if (do_push) begin
            storage[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; a simultaneous push and pop moves
    // both pointers and leaves the count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/picorv32_console_bridge.sv
// ----------------------------------------------------------------------------
// picorv32_console_bridge
// Memory-side stage placed directly after the picorv32 native memory bus.
// Two word addresses form the console window:
//   CONSOLE_ADDR     : TX data register, writes push wdata[7:0] into a FIFO
//   CONSOLE_ADDR + 4 : status register {full, empty, 22'b0, count[7:0]}
// Every other address is forwarded combinationally to the RAM port.
// With STALL_EN set, an xorshift32 generator randomly withholds console
// acceptance to stress the CPU handshake.
// Parameters:
//   CONSOLE_ADDR, FIFO_DEPTH (power of two, 2..256), STALL_EN, STALL_SEED (!= 0)
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   mem         : CPU-side bus (slave)
//   ram         : RAM-side bus (master)
//   out_valid   : TX FIFO non-empty
//   out_data    : TX FIFO head byte
//   out_ready   : sink accepts out_data
// ----------------------------------------------------------------------------
module picorv32_console_bridge
    import picorv32_console_pkg::*;
#(
    parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
    parameter int          FIFO_DEPTH   = 16,
    parameter bit          STALL_EN     = 1'b0,
    parameter logic [31:0] STALL_SEED   = 32'd314159265
) (
    input  logic                             clk,
    input  logic                             reset,
    picorv32_console_bridge_if.slave         mem,
    picorv32_console_bridge_if.master        ram,
    output logic                             out_valid,
    output logic [7:0]                       out_data,
    input  logic                             out_ready
);

    localparam int          CW          = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] STATUS_ADDR = CONSOLE_ADDR + STATUS_OFFSET;

    console_state_t state;
    console_state_t state_next;

    logic          hit_tx;
    logic          hit_st;
    logic          console_hit;
    logic          is_write;
    logic          stall_ok;
    logic          go;
    logic          request;
    logic          accept;
    logic          push;
    logic          pop;
    logic [31:0]   x32;
    logic [31:0]   ack_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [7:0]    count_lo;

    // Full 32-bit address compare, so nothing aliases onto the console.
    assign hit_tx      = (mem.addr == CONSOLE_ADDR);
    assign hit_st      = (mem.addr == STATUS_ADDR);
    assign console_hit = hit_tx | hit_st;
    assign is_write    = |mem.wstrb;

    // A TX write into a full FIFO waits in IDLE; full is the pre-pop value,
    // so a pop only frees the entry for the following cycle.
    assign stall_ok = STALL_EN ? x32[0] : 1'b1;
    assign go       = stall_ok & ~(hit_tx & is_write & fifo_full);
    assign request  = mem.valid & console_hit & go;

    // Non-console traffic passes straight through to RAM.
    assign ram.valid = mem.valid & ~console_hit;
    assign ram.instr = mem.instr;
    assign ram.addr  = mem.addr;
    assign ram.wdata = mem.wdata;
    assign ram.wstrb = mem.wstrb;

    assign pop       = out_valid & out_ready;
    assign out_valid = ~fifo_empty;
    assign count_lo  = 8'(fifo_count);

    // Stall generator runs freely every cycle after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x32 <= STALL_SEED;
        end else begin
            x32 <= xorshift32_step(x32);
        end
    end

    // Console FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Console FSM next state: ACK always lasts exactly one cycle and ignores
    // mem.valid, which prevents a second accept of a held request.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (request) state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Console FSM outputs and CPU-side response mux. In IDLE the RAM answer
    // is forwarded for non-console addresses; console answers only come from
    // the registered ACK state.
    always_comb begin
        accept    = 1'b0;
        push      = 1'b0;
        mem.ready = 1'b0;
        mem.rdata = 32'd0;
        case (state)
            IDLE: begin
                accept = request;
                push   = request & hit_tx & is_write;
                if (!console_hit) begin
                    mem.ready = ram.ready;
                    mem.rdata = ram.rdata;
                end
            end
            ACK: begin
                mem.ready = 1'b1;
                mem.rdata = ack_rdata;
            end
            default: begin
                mem.ready = 1'b0;
                mem.rdata = 32'd0;
            end
        endcase
    end

    // Read data for the ACK cycle, captured when the access is accepted so
    // a status read reflects the FIFO state of the accept cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_rdata <= 32'd0;
        end else if (accept) begin
            ack_rdata <= (hit_st & ~is_write)
                       ? status_word(fifo_full, fifo_empty, count_lo)
                       : 32'd0;
        end
    end

    console_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (mem.wdata[7:0]),
        .full  (fifo_full),
        .pop   (pop),
        .dout  (out_data),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_picorv32_console_bridge.sv
// ----------------------------------------------------------------------------
// tb_picorv32_console_bridge
// Directed bench for picorv32_console_bridge. Two instances share clock and
// reset: dut (no stall) carries the directed console/RAM/reset scenarios,
// dut_stall (STALL_EN=1) carries the random write/sink stress run.
// ----------------------------------------------------------------------------
module tb_picorv32_console_bridge;

    localparam logic [31:0] CONSOLE_ADDR = 32'h1000_0000;
    localparam logic [31:0] STATUS_ADDR  = 32'h1000_0004;
    localparam int          FIFO_DEPTH   = 16;
    localparam logic [31:0] STALL_SEED   = 32'd314159265;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    picorv32_console_bridge_if mem_if ();
    picorv32_console_bridge_if ram_if ();
    picorv32_console_bridge_if s_mem_if ();
    picorv32_console_bridge_if s_ram_if ();

    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       s_out_valid;
    logic [7:0] s_out_data;
    logic       s_out_ready;

    int         assert_count = 0;
    int         fail_count   = 0;
    logic [7:0] popped_q [$];
    logic [7:0] s_exp_q  [$];
    logic       stall_phase = 1'b0;
    logic [31:0] x_model;
    logic [31:0] x_prev;

    picorv32_console_bridge #(
        .CONSOLE_ADDR (CONSOLE_ADDR),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .STALL_EN     (1'b0),
        .STALL_SEED   (STALL_SEED)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem       (mem_if),
        .ram       (ram_if),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    picorv32_console_bridge #(
        .CONSOLE_ADDR (CONSOLE_ADDR),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .STALL_EN     (1'b1),
        .STALL_SEED   (STALL_SEED)
    ) dut_stall (
        .clk       (clk),
        .reset     (reset),
        .mem       (s_mem_if),
        .ram       (s_ram_if),
        .out_valid (s_out_valid),
        .out_data  (s_out_data),
        .out_ready (s_out_ready)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Independent xorshift32 reference (shifts 13, 17, 5).
    function automatic logic [31:0] refXorshift(input logic [31:0] v);
        logic [31:0] t;
        t = v;
        t = t ^ {t[18:0], 13'b0};
        t = t ^ {17'b0, t[31:17]};
        t = t ^ {t[26:0], 5'b0};
        return t;
    endfunction

    // Reference stall generator: x_model is the value of the current cycle,
    // x_prev the value of the cycle before.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            x_model <= STALL_SEED;
            x_prev  <= STALL_SEED;
        end else begin
            x_prev  <= x_model;
            x_model <= refXorshift(x_model);
        end
    end

    // Random sink for the stall instance, changed once per cycle.
    initial begin
        s_out_ready = 1'b0;
        forever begin
            @(negedge clk);
            s_out_ready = stall_phase ? ($urandom_range(0, 1) == 1) : 1'b0;
        end
    end

    // Pre-edge monitor: records pops of both instances, checks the stall
    // stream against its scoreboard, the stall gating and FIFO bounds.
    always @(negedge clk) begin
        #4;
        if (!reset) begin
            if (out_valid && out_ready) begin
                popped_q.push_back(out_data);
            end
            if (s_out_valid && s_out_ready) begin
                checkOutput("stall_sb_nonempty", 32'(s_exp_q.size() != 0), 32'd1);
                if (s_exp_q.size() != 0) begin
                    checkOutput("stall_byte", 32'(s_out_data), 32'(s_exp_q.pop_front()));
                end
            end
            if (s_mem_if.ready) begin
                checkOutput("stall_ack_after_x0", 32'(x_prev[0]), 32'd1);
            end
            if (stall_phase) begin
                checkOutput("stall_fifo_bound",
                            32'(dut_stall.u_fifo.count <= FIFO_DEPTH), 32'd1);
            end
        end
    end

    // One console access on dut: checks RAM isolation, ack latency, read
    // data and that mem_ready drops after one cycle with valid still held.
    task automatic applyStimulus(input string tag, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] wstrb,
                                 input int exp_lat, input logic [31:0] exp_rdata);
        int lat;
        lat          = 0;
        mem_if.valid = 1'b1;
        mem_if.instr = 1'b0;
        mem_if.addr  = addr;
        mem_if.wdata = wdata;
        mem_if.wstrb = wstrb;
        #1;
        checkOutput({tag, "_ram_valid"}, 32'(ram_if.valid), 32'd0);
        while (!mem_if.ready && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        checkOutput({tag, "_rdata"}, mem_if.rdata, exp_rdata);
        @(negedge clk);
        checkOutput({tag, "_ready_one_cycle"}, 32'(mem_if.ready), 32'd0);
        mem_if.valid = 1'b0;
        mem_if.wstrb = 4'd0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          lat;
        logic [31:0] wd;
        logic [3:0]  ws;

        reset          = 1'b1;
        out_ready      = 1'b0;
        mem_if.valid   = 1'b0;
        mem_if.instr   = 1'b0;
        mem_if.addr    = CONSOLE_ADDR;
        mem_if.wdata   = 32'd0;
        mem_if.wstrb   = 4'd0;
        ram_if.ready   = 1'b0;
        ram_if.rdata   = 32'd0;
        s_mem_if.valid = 1'b0;
        s_mem_if.instr = 1'b0;
        s_mem_if.addr  = CONSOLE_ADDR;
        s_mem_if.wdata = 32'd0;
        s_mem_if.wstrb = 4'd0;
        s_ram_if.ready = 1'b0;
        s_ram_if.rdata = 32'd0;

        // Reset state.
        #2;
        checkOutput("rst_mem_ready", 32'(mem_if.ready), 32'd0);
        checkOutput("rst_mem_rdata", mem_if.rdata, 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_s_out_valid", 32'(s_out_valid), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Three TX writes with a free-running sink, varied strobes.
        out_ready = 1'b1;
        applyStimulus("tx41", CONSOLE_ADDR, 32'hAABBCC41, 4'b0001, 1, 32'd0);
        applyStimulus("tx42", CONSOLE_ADDR, 32'h11223342, 4'b1000, 1, 32'd0);
        applyStimulus("tx43", CONSOLE_ADDR, 32'h00000043, 4'b0110, 1, 32'd0);
        repeat (4) @(negedge clk);
        checkOutput("abc_count", 32'(popped_q.size()), 32'd3);
        if (popped_q.size() == 3) begin
            checkOutput("abc_byte0", 32'(popped_q[0]), 32'h41);
            checkOutput("abc_byte1", 32'(popped_q[1]), 32'h42);
            checkOutput("abc_byte2", 32'(popped_q[2]), 32'h43);
        end
        applyStimulus("status_empty", STATUS_ADDR, 32'd0, 4'd0, 1, 32'h4000_0000);
        popped_q.delete();

        // Fill to 16 with a blocked sink, probing the status register.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus("fill_a", CONSOLE_ADDR, 32'h60 + i, 4'b0001, 1, 32'd0);
        end
        applyStimulus("status_5", STATUS_ADDR, 32'd0, 4'd0, 1, 32'h0000_0005);
        applyStimulus("tx_read", CONSOLE_ADDR, 32'd0, 4'd0, 1, 32'd0);
        applyStimulus("status_write", STATUS_ADDR, 32'hFFFF_FFFF, 4'hF, 1, 32'd0);
        applyStimulus("status_5_again", STATUS_ADDR, 32'd0, 4'd0, 1, 32'h0000_0005);
        for (int i = 5; i < 16; i++) begin
            applyStimulus("fill_b", CONSOLE_ADDR, 32'h60 + i, 4'b0001, 1, 32'd0);
        end
        applyStimulus("status_full", STATUS_ADDR, 32'd0, 4'd0, 1, 32'h8000_0010);

        // 17th write stalls until the sink frees an entry.
        mem_if.valid = 1'b1;
        mem_if.addr  = CONSOLE_ADDR;
        mem_if.wdata = 32'h70;
        mem_if.wstrb = 4'b0001;
        repeat (4) begin
            @(negedge clk);
            checkOutput("full_hold_ready", 32'(mem_if.ready), 32'd0);
        end
        out_ready = 1'b1;
        lat = 0;
        while (!mem_if.ready && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("full_release_latency", 32'(lat), 32'd2);
        @(negedge clk);
        checkOutput("full_release_one_cycle", 32'(mem_if.ready), 32'd0);
        mem_if.valid = 1'b0;
        mem_if.wstrb = 4'd0;
        repeat (24) @(negedge clk);
        checkOutput("drain_count", 32'(popped_q.size()), 32'd17);
        for (int i = 0; i < popped_q.size(); i++) begin
            checkOutput("drain_byte", 32'(popped_q[i]), 32'h60 + i);
        end
        checkOutput("drain_out_valid", 32'(out_valid), 32'd0);
        popped_q.delete();

        // RAM read at 0x100 answered after three cycles.
        mem_if.valid = 1'b1;
        mem_if.instr = 1'b1;
        mem_if.addr  = 32'h0000_0100;
        mem_if.wdata = 32'd0;
        mem_if.wstrb = 4'd0;
        #1;
        checkOutput("ram_rd_valid", 32'(ram_if.valid), 32'd1);
        checkOutput("ram_rd_addr", ram_if.addr, 32'h0000_0100);
        checkOutput("ram_rd_instr", 32'(ram_if.instr), 32'd1);
        checkOutput("ram_rd_wait", 32'(mem_if.ready), 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("ram_rd_wait2", 32'(mem_if.ready), 32'd0);
        @(negedge clk);
        ram_if.ready = 1'b1;
        ram_if.rdata = 32'hDEAD_BEEF;
        #1;
        checkOutput("ram_rd_ready", 32'(mem_if.ready), 32'd1);
        checkOutput("ram_rd_rdata", mem_if.rdata, 32'hDEAD_BEEF);
        @(negedge clk);
        ram_if.ready = 1'b0;
        ram_if.rdata = 32'd0;
        mem_if.valid = 1'b0;
        mem_if.instr = 1'b0;

        // RAM write just past the console window: no aliasing.
        @(negedge clk);
        mem_if.valid = 1'b1;
        mem_if.addr  = CONSOLE_ADDR + 32'd8;
        mem_if.wdata = 32'h1234_5678;
        mem_if.wstrb = 4'b0101;
        ram_if.ready = 1'b1;
        #1;
        checkOutput("ram_wr_valid", 32'(ram_if.valid), 32'd1);
        checkOutput("ram_wr_wdata", ram_if.wdata, 32'h1234_5678);
        checkOutput("ram_wr_wstrb", 32'(ram_if.wstrb), 32'h5);
        checkOutput("ram_wr_ready", 32'(mem_if.ready), 32'd1);
        @(negedge clk);
        mem_if.valid = 1'b0;
        mem_if.wstrb = 4'd0;
        ram_if.ready = 1'b0;
        @(negedge clk);

        // Reset in the middle of an ACK with three bytes queued.
        out_ready = 1'b0;
        applyStimulus("pre_rst_a", CONSOLE_ADDR, 32'h31, 4'b0001, 1, 32'd0);
        applyStimulus("pre_rst_b", CONSOLE_ADDR, 32'h32, 4'b0001, 1, 32'd0);
        applyStimulus("pre_rst_c", CONSOLE_ADDR, 32'h33, 4'b0001, 1, 32'd0);
        mem_if.valid = 1'b1;
        mem_if.addr  = CONSOLE_ADDR;
        mem_if.wdata = 32'h99;
        mem_if.wstrb = 4'b0001;
        @(negedge clk);
        checkOutput("mid_ack_ready", 32'(mem_if.ready), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("rst_mid_ready", 32'(mem_if.ready), 32'd0);
        checkOutput("rst_mid_out_valid", 32'(out_valid), 32'd0);
        mem_if.valid = 1'b0;
        mem_if.wstrb = 4'd0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        applyStimulus("post_rst_tx", CONSOLE_ADDR, 32'h5A, 4'b0001, 1, 32'd0);
        applyStimulus("post_rst_status", STATUS_ADDR, 32'd0, 4'd0, 1, 32'h0000_0001);
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("post_rst_count", 32'(popped_q.size()), 32'd1);
        if (popped_q.size() == 1) begin
            checkOutput("post_rst_byte", 32'(popped_q[0]), 32'h5A);
        end

        // Stall stress: 1000 random writes against a random sink.
        stall_phase = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            wd = $urandom;
            ws = 4'($urandom_range(1, 15));
            s_exp_q.push_back(wd[7:0]);
            s_mem_if.valid = 1'b1;
            s_mem_if.addr  = CONSOLE_ADDR;
            s_mem_if.wdata = wd;
            s_mem_if.wstrb = ws;
            lat = 0;
            while (!s_mem_if.ready && lat < 200) begin
                @(negedge clk);
                lat++;
            end
            checkOutput("stall_ack_in_time", 32'(lat < 200), 32'd1);
            @(negedge clk);
            s_mem_if.valid = 1'b0;
            s_mem_if.wstrb = 4'd0;
        end
        lat = 0;
        while (s_exp_q.size() != 0 && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
        @(negedge clk);
        checkOutput("stall_drained", 32'(s_exp_q.size()), 32'd0);
        checkOutput("stall_out_valid", 32'(s_out_valid), 32'd0);
        stall_phase = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assert_count, fail_count);
        $finish;
    end

endmodule
